cordic_phase_sweep: RTL

Upstream feeder for the sine_cosine CORDIC stage. The block generates a stream of phase words from a phase accumulator with a programmable step, and drives the gain-compensated X/Y seed. It also produces a valid flag aligned to the CORDIC output so downstream capture logic knows which Xout/Yout samples are real. A single start pulse runs one sweep of COUNT samples; done is pulsed once the last sample has left the CORDIC pipeline.

---
 rtl/cordic_pkg.sv | 38 +++
 rtl/cordic_phase_sweep_valid_delay_line.sv | 40 ++++
 rtl/cordic_phase_sweep.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared constants and types for the CORDIC phase-sweep feeder and its bench.
//   PHASE_W   : phase word width, 2^PHASE_W == 360 deg
//   SZ        : X/Y seed width
//   LATENCY   : CORDIC pipeline depth, angle-in to Xout/Yout-out
//   CNT_W     : sample counter width
//   X_SEED    : gain-compensated X seed, floor(32000/1.647)
//   DEG1_STEP : phase step for one degree per sample
// -----------------------------------------------------------------------------
package cordic_pkg;

  localparam int PHASE_W = 32;
  localparam int SZ      = 16;
  localparam int LATENCY = 16;
  localparam int CNT_W   = 16;

  localparam logic [SZ-1:0]      X_SEED    = 16'd19429;
  localparam logic [PHASE_W-1:0] DEG1_STEP = 32'h00B6_0B60;
  localparam logic [CNT_W-1:0]   CNT_ONE   = 16'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } sweep_state_e;

  // Phase accumulator step: unsigned add, carry out of the top bit dropped,
  // so the phase wraps naturally at 360 deg.
  function automatic logic [PHASE_W-1:0] next_phase(
    input logic [PHASE_W-1:0] acc,
    input logic [PHASE_W-1:0] step
  );
    next_phase = acc + step;
  endfunction

endpackage

// File: rtl/cordic_phase_sweep_valid_delay_line.sv
// -----------------------------------------------------------------------------
// valid_delay_line
// DEPTH-deep 1-bit shift register that tracks which samples are still inside
// the CORDIC pipeline.
//   i_clk         : clock, rising edge
//   i_rst_n       : asynchronous active-low reset
//   i_valid       : valid flag entering the pipeline (angle_valid)
//   o_valid       : i_valid delayed by exactly DEPTH clocks
//   o_any_pending : a sample still has two or more stages to travel
// -----------------------------------------------------------------------------
module valid_delay_line #(
  parameter int DEPTH = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  output logic o_valid,
  output logic o_any_pending
);

  logic [DEPTH-1:0] r_sr;

  // Shift the valid flag one stage per clock, in every state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else begin
      r_sr <= {r_sr[DEPTH-2:0], i_valid};
    end
  end

  assign o_valid = r_sr[DEPTH-1];

  // The top two stages are left out on purpose. The controller leaves FLUSH
  // when this drops, spends one cycle in DONE, and registers done on the
  // next edge. That places done exactly one cycle after the last o_valid.
  // DEPTH must be at least 3.
  assign o_any_pending = i_valid | (|r_sr[DEPTH-3:0]);

endmodule

// File: rtl/cordic_phase_sweep.sv
// -----------------------------------------------------------------------------
// cordic_phase_sweep
// Feeds the sine_cosine CORDIC stage. It generates one sweep of phase words
// from a programmable-step accumulator and holds the gain-compensated X/Y
// seed constant. It also provides a valid flag aligned to the CORDIC output.
//   CLK_100MHZ  : system clock, rising edge
//   RST_N       : asynchronous active-low reset
//   start       : one-cycle sweep request, accepted only in IDLE
//   step        : phase increment per sample, latched with start
//   count       : samples in the sweep, latched with start
//   busy        : high while in RUN or FLUSH
//   done        : one-cycle pulse after the last sample leaves the CORDIC
//   angle       : phase word to the CORDIC
//   Xin / Yin   : constant seed to the CORDIC
//   angle_valid : angle carries a sweep sample
//   out_valid   : angle_valid delayed by LATENCY clocks
//   sample_idx  : index of the sample currently on angle
// -----------------------------------------------------------------------------
module cordic_phase_sweep
  import cordic_pkg::*;
(
  input  logic               CLK_100MHZ,
  input  logic               RST_N,
  input  logic               start,
  input  logic [PHASE_W-1:0] step,
  input  logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic [PHASE_W-1:0] angle,
  output logic [SZ-1:0]      Xin,
  output logic [SZ-1:0]      Yin,
  output logic               angle_valid,
  output logic               out_valid,
  output logic [CNT_W-1:0]   sample_idx
);

  sweep_state_e       r_state;
  sweep_state_e       w_next_state;

  logic [PHASE_W-1:0] r_step;
  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_angle;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_remaining;
  logic [CNT_W-1:0]   r_sample_idx;
  logic               r_busy;
  logic               r_done;
  logic               r_angle_valid;
  logic [SZ-1:0]      r_xin;
  logic [SZ-1:0]      r_yin;

  logic               w_out_valid;
  logic               w_any_pending;

  // State register.
  always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = (count == '0) ? DONE : RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        // remaining == 1 means this clock emits the last sample.
        if (r_remaining == CNT_ONE) begin
          w_next_state = FLUSH;
        end else begin
          w_next_state = RUN;
        end
      end
      FLUSH: begin
        if (!w_any_pending) begin
          w_next_state = DONE;
        end else begin
          w_next_state = FLUSH;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Sweep datapath: latch the request, step the accumulator, register outputs.
  always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_step        <= '0;
      r_acc         <= '0;
      r_angle       <= '0;
      r_count       <= '0;
      r_remaining   <= '0;
      r_sample_idx  <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_angle_valid <= 1'b0;
    end else begin
      r_busy        <= (w_next_state == RUN) || (w_next_state == FLUSH);
      r_done        <= (r_state == DONE);
      r_angle_valid <= (r_state == RUN);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_step      <= step;
            r_count     <= count;
            r_remaining <= count;
            r_acc       <= '0;
          end
        end
        RUN: begin
          r_angle      <= r_acc;
          r_sample_idx <= r_count - r_remaining;
          r_acc        <= next_phase(r_acc, r_step);
          r_remaining  <= r_remaining - CNT_ONE;
        end
        default: begin
          // FLUSH and DONE hold angle, index and accumulator.
        end
      endcase
    end
  end

  // Seed registers: loaded at reset and held constant afterwards.
  always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_xin <= X_SEED;
      r_yin <= '0;
    end else begin
      r_xin <= X_SEED;
      r_yin <= '0;
    end
  end

  valid_delay_line #(
    .DEPTH (LATENCY)
  ) u_valid_delay_line (
    .i_clk         (CLK_100MHZ),
    .i_rst_n       (RST_N),
    .i_valid       (r_angle_valid),
    .o_valid       (w_out_valid),
    .o_any_pending (w_any_pending)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign angle       = r_angle;
  assign Xin         = r_xin;
  assign Yin         = r_yin;
  assign angle_valid = r_angle_valid;
  assign out_valid   = w_out_valid;
  assign sample_idx  = r_sample_idx;

endmodule
